// File: rtl/mash11_stream_mod.sv
// mash11_stream_mod: zero-order-hold resampler feeding a MASH 1-1 noise shaper
// that emits a 2-bit offset DAC code every aclk cycle.
module mash11_stream_mod #(
    parameter int DATA_WIDTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  arst_n,
    input  logic [DIV_WIDTH-1:0]  osr_div,
    input  logic [DATA_WIDTH-1:0] s_axis_data_tdata,
    input  logic                  s_axis_data_tvalid,
    output logic                  s_axis_data_tready,
    output logic [1:0]            dac_code,
    output logic                  dac_valid,
    output logic                  underflow
);
    logic [DATA_WIDTH-1:0] x_reg, acc1, acc2;
    logic [DIV_WIDTH-1:0]  div_cnt;
    logic                  running, c2_d;
    logic [DATA_WIDTH:0]   s1, s2;
    logic [1:0]            code_next;

    assign s_axis_data_tready = div_cnt == '0;

    always_comb begin
        s1 = {1'b0, acc1} + {1'b0, x_reg};
        s2 = {1'b0, acc2} + {1'b0, s1[DATA_WIDTH-1:0]};
        // y lies in -1..2, so y+1 computed modulo 4 is exactly the offset code
        code_next = 2'd1 + {1'b0, s1[DATA_WIDTH]} + {1'b0, s2[DATA_WIDTH]} - {1'b0, c2_d};
    end

    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            x_reg     <= '0;
            acc1      <= '0;
            acc2      <= '0;
            c2_d      <= 1'b0;
            div_cnt   <= '0;
            running   <= 1'b0;
            underflow <= 1'b0;
            dac_code  <= 2'd1;
            dac_valid <= 1'b0;
        end else begin
            if (!s_axis_data_tready)
                div_cnt <= div_cnt - DIV_WIDTH'(1);
            else if (s_axis_data_tvalid) begin
                x_reg   <= s_axis_data_tdata;
                div_cnt <= osr_div;
                running <= 1'b1;
            end else if (running)
                underflow <= 1'b1;
            if (running) begin
                acc1      <= s1[DATA_WIDTH-1:0];
                acc2      <= s2[DATA_WIDTH-1:0];
                c2_d      <= s2[DATA_WIDTH];
                dac_code  <= code_next;
                dac_valid <= 1'b1;
            end else begin
                dac_code  <= 2'd1;
                dac_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mash11_stream_mod.sv
// tb_mash11_stream_mod: randomized and directed checks of the MASH 1-1 stream
// modulator against an arithmetic reference model.
module tb_mash11_stream_mod;
    logic        aclk = 1'b0;
    logic        arst_n;
    logic [15:0] osr_div;
    logic [15:0] tdata;
    logic        tvalid;
    logic        tready;
    logic [1:0]  dac_code;
    logic        dac_valid;
    logic        underflow;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    mash11_stream_mod dut (
        .aclk(aclk),
        .arst_n(arst_n),
        .osr_div(osr_div),
        .s_axis_data_tdata(tdata),
        .s_axis_data_tvalid(tvalid),
        .s_axis_data_tready(tready),
        .dac_code(dac_code),
        .dac_valid(dac_valid),
        .underflow(underflow)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic, slot timing kept as an absolute cycle number
    longint cyc = 0, next_slot = 0;
    int  m_x, m_acc1, m_acc2, m_c2d, m_code, m_valid, m_uf;
    bit  m_run;

    always @(posedge aclk) begin
        int s1, s2, c1, c2, y;
        if (!arst_n) begin
            m_run = 0; m_x = 0; m_acc1 = 0; m_acc2 = 0; m_c2d = 0;
            m_code = 1; m_valid = 0; m_uf = 0; next_slot = 0;
        end else begin
            if (m_run) begin
                s1 = m_acc1 + m_x;
                c1 = s1 / 65536;
                m_acc1 = s1 % 65536;
                s2 = m_acc2 + m_acc1;
                c2 = s2 / 65536;
                m_acc2 = s2 % 65536;
                y = c1 + c2 - m_c2d;
                m_c2d = c2;
                m_code = y + 1;
                m_valid = 1;
            end else begin
                m_code = 1;
                m_valid = 0;
            end
            if (cyc >= next_slot) begin
                if (tvalid) begin
                    m_x = int'(tdata);
                    next_slot = cyc + longint'(osr_div) + 1;
                    m_run = 1;
                end else if (m_run)
                    m_uf = 1;
            end
        end
        cyc++;
    end

    always @(negedge aclk) begin
        if (check_en) begin
            chk("tready", 32'(tready), 32'(cyc >= next_slot));
            chk("dac_code", 32'(dac_code), 32'(m_code));
            chk("dac_valid", 32'(dac_valid), 32'(m_valid));
            chk("underflow", 32'(underflow), 32'(m_uf));
        end
    end

    task automatic adv();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        adv();
        chk("rst_code", 32'(dac_code), 32'd1);
        chk("rst_valid", 32'(dac_valid), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_tready", 32'(tready), 32'd1);
        arst_n = 1'b1;
    endtask

    task automatic run_seq(input int n);
        int seq [4] = '{1, 2, 2, 1};
        @(posedge aclk);
        for (int i = 0; i < n; i++) begin
            adv();
            chk("seq_8000", 32'(dac_code), 32'(seq[i % 4]));
        end
    endtask

    initial begin
        int dut_sum, cnt;
        bit found;
        arst_n = 1'b0; osr_div = '0; tvalid = 1'b0; tdata = '0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check_en = 1'b1;
        chk("init_code", 32'(dac_code), 32'd1);
        chk("init_valid", 32'(dac_valid), 32'd0);
        chk("init_tready", 32'(tready), 32'd1);

        // x = 0: flat output, valid one edge after the first handshake
        arst_n = 1'b1; tvalid = 1'b1; tdata = 16'h0000;
        adv();
        chk("valid_at_handshake", 32'(dac_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            adv();
            chk("zero_code", 32'(dac_code), 32'd1);
            chk("zero_valid", 32'(dac_valid), 32'd1);
            chk("zero_tready", 32'(tready), 32'd1);
        end

        // half scale: period-4 pattern, then a mid-stream reset restarts it
        do_reset();
        tdata = 16'h8000;
        run_seq(10);
        do_reset();
        run_seq(8);

        // full scale: long-run mean
        do_reset();
        tdata = 16'hFFFF;
        @(posedge aclk);
        dut_sum = 0;
        repeat (65536) begin
            adv();
            dut_sum += int'(dac_code) - 1;
        end
        if (dut_sum < 65535 || dut_sum > 65536) begin
            n_checks++; n_fail++;
            $display("FAIL sum_ffff: got %0d expected 65535..65536", dut_sum);
        end else
            n_checks++;

        // no underflow before the first sample
        tvalid = 1'b0;
        do_reset();
        repeat (3) adv();
        chk("no_uf_before_first", 32'(underflow), 32'd0);

        // osr_div = 3 with continuous valid: one handshake in four
        osr_div = 16'd3; tvalid = 1'b1;
        do_reset();
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tdata = 16'($urandom);
            if (tready) cnt++;
            adv();
        end
        chk("ready_pulses", 32'(cnt), 32'd4);
        chk("uf_full_rate", 32'(underflow), 32'd0);

        // drop valid for a slot: ready held high, underflow sticky
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (tready) found = 1'b1;
            else adv();
        end
        chk("ready_wait", 32'(found), 32'd1);
        tvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            adv();
            chk("uf_set", 32'(underflow), 32'd1);
            chk("ready_hold", 32'(tready), 32'd1);
        end
        tvalid = 1'b1;
        repeat (6) adv();
        chk("uf_sticky", 32'(underflow), 32'd1);

        // randomized stream with rate changes and rare resets
        do_reset();
        repeat (3000) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            if ($urandom_range(0, 7) == 0) osr_div = 16'($urandom_range(0, 3));
            tvalid = $urandom_range(0, 4) != 0;
            tdata = 16'($urandom);
            adv();
        end

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
